// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N packet sources.
// It grants a whole 0xFF-terminated packet at a time and kills packets whose source stalls.
module uart_tx_arbiter #(
  parameter int unsigned N         = 4,
  parameter int unsigned HEADER_EN = 1,
  parameter int unsigned STALL_MAX = 1023
) (
  input  logic           Clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           tx_en,
  output logic [7:0]     tx_data,
  input  logic           tx_done,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           abort
);

  localparam int unsigned SW       = $clog2(STALL_MAX + 1);
  localparam logic [2:0]  LastInit = 3'(N - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StLoad, StSend} state_e;

  state_e        state_q, state_d;
  logic [2:0]    id_q, last_id_q, win_id;
  logic [N-1:0]  grant_q, win_oh;
  logic          win_found;
  logic          tx_en_q, last_q, abort_q;
  logic [7:0]    tx_data_q, sel_data;
  logic          sel_valid;
  logic [SW-1:0] stall_q;
  logic          stall_hit;

  // Two passes give the rotated scan: sources above last_id first, then wrap.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req_valid[i] && (i > int'(last_id_q))) begin
        win_found = 1'b1;
        win_id    = 3'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!win_found && req_valid[i] && (i <= int'(last_id_q))) begin
        win_found = 1'b1;
        win_id    = 3'(i);
      end
    end
    win_oh = '0;
    for (int i = 0; i < N; i++) begin
      win_oh[i] = win_found && (3'(i) == win_id);
    end
  end

  always_comb begin
    sel_valid = |(req_valid & grant_q);
    sel_data  = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) sel_data = req_data[8*i +: 8];
    end
  end

  assign stall_hit = (stall_q == SW'(STALL_MAX - 1));

  always_ff @(posedge Clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_found) state_d = (HEADER_EN != 0) ? StHdr : StLoad;
      StHdr:   if (tx_done) state_d = StLoad;
      StLoad:  if (sel_valid || stall_hit) state_d = StSend;
      StSend:  if (tx_done) state_d = last_q ? StIdle : StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StLoad) ? (req_valid & grant_q) : '0;
    busy      = (state_q != StIdle);
    tx_en     = tx_en_q;
    tx_data   = tx_data_q;
    grant     = grant_q;
    abort     = abort_q;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      id_q      <= 3'd0;
      last_id_q <= LastInit;
      grant_q   <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
      last_q    <= 1'b0;
      abort_q   <= 1'b0;
      stall_q   <= '0;
    end else begin
      abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            grant_q <= win_oh;
            id_q    <= win_id;
            if (HEADER_EN != 0) begin
              tx_data_q <= {5'b11100, win_id};
              tx_en_q   <= 1'b1;
            end
          end
        end
        StHdr: begin
          if (tx_done) tx_en_q <= 1'b0;
        end
        StLoad: begin
          if (sel_valid) begin
            tx_data_q <= sel_data;
            tx_en_q   <= 1'b1;
            last_q    <= (sel_data == 8'hFF);
            stall_q   <= '0;
          end else if (stall_hit) begin
            // Source went silent: close the frame with our own terminator.
            tx_data_q <= 8'hFF;
            tx_en_q   <= 1'b1;
            last_q    <= 1'b1;
            abort_q   <= 1'b1;
            stall_q   <= '0;
          end else begin
            stall_q <= stall_q + SW'(1);
          end
        end
        StSend: begin
          if (tx_done) begin
            tx_en_q <= 1'b0;
            if (last_q) begin
              last_id_q <= id_q;
              grant_q   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: dut 0 has headers enabled, dut 1 has them disabled; only the selected one
// sees source traffic. A monitor per dut pops expected bytes on every tx_en rising edge.
module tb_uart_tx_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned STALL = 15;

  typedef struct packed {
    logic         dut;
    logic [7:0]   data;
    logic [N-1:0] grant;
  } exp_t;

  logic           Clk;
  logic           reset;
  logic           sel;
  logic           spur;
  logic [N-1:0]   src_valid;
  logic [8*N-1:0] src_data;

  logic [N-1:0] req_valid_w [2];
  logic [N-1:0] req_ready_w [2];
  logic [N-1:0] grant_w     [2];
  logic         tx_en_w     [2];
  logic [7:0]   tx_data_w   [2];
  logic         tx_done_w   [2];
  logic         busy_w      [2];
  logic         abort_w     [2];
  logic         done_m      [2];

  logic [7:0] src_mem  [N][32];
  int         src_head [N];
  int         src_tail [N];
  int         ready_cnt [2][N];
  int         abort_cnt [2];
  exp_t       exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic void check_eq(input string name, input logic [31:0] act,
                                   input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endfunction

  function automatic void refresh();
    for (int i = 0; i < N; i++) begin
      src_valid[i]        = (src_head[i] != src_tail[i]);
      src_data[8*i +: 8]  = src_valid[i] ? src_mem[i][src_head[i]] : 8'h00;
    end
  endfunction

  function automatic void push_src(input int s, input logic [7:0] b);
    src_mem[s][src_tail[s]] = b;
    src_tail[s]++;
    refresh();
  endfunction

  function automatic void push_exp(input logic dut, input logic [7:0] data,
                                   input logic [N-1:0] g);
    exp_t e;
    e.dut   = dut;
    e.data  = data;
    e.grant = g;
    exp_q.push_back(e);
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    assign req_valid_w[d] = (sel == 1'(d)) ? src_valid : '0;
    assign tx_done_w[d]   = done_m[d] | (spur && (sel == 1'(d)));

    uart_tx_arbiter #(
      .N         (N),
      .HEADER_EN (d == 0 ? 1 : 0),
      .STALL_MAX (STALL)
    ) u_dut (
      .Clk       (Clk),
      .reset     (reset),
      .req_valid (req_valid_w[d]),
      .req_data  (src_data),
      .req_ready (req_ready_w[d]),
      .tx_en     (tx_en_w[d]),
      .tx_data   (tx_data_w[d]),
      .tx_done   (tx_done_w[d]),
      .grant     (grant_w[d]),
      .busy      (busy_w[d]),
      .abort     (abort_w[d])
    );

    // UART model: done pulse 10 cycles after each tx_en rise.
    initial begin : p_uart
      int   cnt;
      logic prev;
      done_m[d] = 1'b0;
      cnt       = 0;
      prev      = 1'b0;
      forever begin
        @(negedge Clk);
        done_m[d] = 1'b0;
        if (reset) cnt = 0;
        else if (tx_en_w[d] && !prev) cnt = 10;
        else if (cnt > 0) begin
          if (cnt == 1) done_m[d] = 1'b1;
          cnt--;
        end
        prev = tx_en_w[d];
      end
    end

    initial begin : p_mon
      logic       prev_en;
      logic [7:0] prev_data;
      exp_t       e;
      exp_t       got;
      prev_en      = 1'b0;
      prev_data    = 8'h00;
      abort_cnt[d] = 0;
      for (int i = 0; i < N; i++) ready_cnt[d][i] = 0;
      forever begin
        @(negedge Clk);
        check_eq("busy_vs_grant", 32'(busy_w[d]), 32'(|grant_w[d]));
        check_eq("ready_outside_grant", 32'(req_ready_w[d] & ~grant_w[d]), 0);
        if (tx_en_w[d] && !prev_en) begin
          got.dut   = 1'(d);
          got.data  = tx_data_w[d];
          got.grant = grant_w[d];
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: dut%0d sent %h, nothing expected", d, tx_data_w[d]);
          end else begin
            e = exp_q.pop_front();
            check_eq("byte{dut,data,grant}", 32'(got), 32'(e));
          end
        end
        if (tx_en_w[d] && prev_en) check_eq("tx_data_stable", 32'(tx_data_w[d]), 32'(prev_data));
        if (abort_w[d]) begin
          abort_cnt[d]++;
          check_eq("abort_with_ff", 32'({tx_en_w[d], tx_data_w[d]}), 32'h1FF);
        end
        for (int i = 0; i < N; i++) if (req_ready_w[d][i]) ready_cnt[d][i]++;
        prev_en   = tx_en_w[d];
        prev_data = tx_data_w[d];
      end
    end
  end

  // Source model: a byte is consumed on the edge where req_ready was high.
  initial begin : p_src
    logic [N-1:0] rdy;
    forever begin
      @(negedge Clk);
      rdy = req_ready_w[sel];
      @(posedge Clk);
      #1;
      for (int i = 0; i < N; i++) if (rdy[i]) src_head[i]++;
      refresh();
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge Clk);
    check_eq("rst_tx_en",     32'(tx_en_w[sel]),     0);
    check_eq("rst_tx_data",   32'(tx_data_w[sel]),   0);
    check_eq("rst_req_ready", 32'(req_ready_w[sel]), 0);
    check_eq("rst_grant",     32'(grant_w[sel]),     0);
    check_eq("rst_busy",      32'(busy_w[sel]),      0);
    check_eq("rst_abort",     32'(abort_w[sel]),     0);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while ((exp_q.size() != 0 || busy_w[sel]) && n < budget);
    check_eq("pending_bytes", 32'(exp_q.size()), 0);
    check_eq("busy_after_drain", 32'(busy_w[sel]), 0);
    check_eq("grant_after_drain", 32'(grant_w[sel]), 0);
  endtask

  initial begin : p_main
    int base0, base2, r1, a0, n, cyc;
    logic seen;
    reset = 1'b1;
    sel   = 1'b0;
    spur  = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    refresh();
    @(negedge Clk);
    do_reset();

    // Single source, three bytes with header.
    base0 = ready_cnt[0][0];
    push_exp(1'b0, 8'hE0, 4'b0001);
    push_exp(1'b0, 8'h51, 4'b0001);
    push_exp(1'b0, 8'h52, 4'b0001);
    push_exp(1'b0, 8'hFF, 4'b0001);
    push_src(0, 8'h51);
    push_src(0, 8'h52);
    push_src(0, 8'hFF);
    wait_idle(300);
    check_eq("t1_ready_pulses", 32'(ready_cnt[0][0] - base0), 3);

    // Sources 0 and 2 contend: strict alternation 0,2,0,2.
    do_reset();
    base0 = ready_cnt[0][0];
    base2 = ready_cnt[0][2];
    for (int k = 0; k < 2; k++) begin
      push_exp(1'b0, 8'hE0, 4'b0001);
      push_exp(1'b0, 8'hA0, 4'b0001);
      push_exp(1'b0, 8'hFF, 4'b0001);
      push_exp(1'b0, 8'hE2, 4'b0100);
      push_exp(1'b0, 8'hC0, 4'b0100);
      push_exp(1'b0, 8'hFF, 4'b0100);
      push_src(0, 8'hA0);
      push_src(0, 8'hFF);
      push_src(2, 8'hC0);
      push_src(2, 8'hFF);
    end
    wait_idle(800);
    check_eq("t2_ready_src0", 32'(ready_cnt[0][0] - base0), 4);
    check_eq("t2_ready_src2", 32'(ready_cnt[0][2] - base2), 4);

    // Source 1 stalls after one byte; watchdog closes the packet.
    do_reset();
    r1 = ready_cnt[0][1];
    a0 = abort_cnt[0];
    push_exp(1'b0, 8'hE1, 4'b0010);
    push_exp(1'b0, 8'h41, 4'b0010);
    push_exp(1'b0, 8'hFF, 4'b0010);
    push_src(1, 8'h41);
    n = 0;
    while (ready_cnt[0][1] == r1 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    n    = 0;
    seen = 1'b0;
    while (!(seen && !tx_en_w[0]) && n < 200) begin
      @(negedge Clk);
      if (tx_en_w[0]) seen = 1'b1;
      n++;
    end
    // First LOAD cycle observed; a spurious done lands mid-stall.
    cyc = 1;
    while (!tx_en_w[0] && cyc < 100) begin
      @(negedge Clk);
      cyc++;
      spur = (cyc == 4);
    end
    spur = 1'b0;
    check_eq("t3_stall_cycles", 32'(cyc), 16);
    check_eq("t3_stall_tx_data", 32'(tx_data_w[0]), 32'hFF);
    wait_idle(300);
    check_eq("t3_abort_count", 32'(abort_cnt[0] - a0), 1);
    check_eq("t3_ready_src1", 32'(ready_cnt[0][1] - r1), 1);
    // Spurious done while idle must do nothing.
    spur = 1'b1;
    @(negedge Clk);
    spur = 1'b0;
    repeat (3) @(negedge Clk);
    check_eq("idle_spur_busy", 32'(busy_w[0]), 0);
    check_eq("idle_spur_tx_en", 32'(tx_en_w[0]), 0);
    push_exp(1'b0, 8'hE3, 4'b1000);
    push_exp(1'b0, 8'h33, 4'b1000);
    push_exp(1'b0, 8'hFF, 4'b1000);
    push_src(3, 8'h33);
    push_src(3, 8'hFF);
    wait_idle(300);
    check_eq("t3_abort_total", 32'(abort_cnt[0] - a0), 1);

    // Reset in the middle of source 2's packet; source 0 must win afterwards.
    do_reset();
    base2 = ready_cnt[0][2];
    push_exp(1'b0, 8'hE2, 4'b0100);
    push_exp(1'b0, 8'hB0, 4'b0100);
    push_src(2, 8'hB0);
    push_src(2, 8'hB1);
    push_src(2, 8'hFF);
    n = 0;
    while (!(ready_cnt[0][2] != base2 && tx_en_w[0]) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    reset = 1'b1;
    @(negedge Clk);
    check_eq("mid_rst_tx_en",     32'(tx_en_w[0]),     0);
    check_eq("mid_rst_tx_data",   32'(tx_data_w[0]),   0);
    check_eq("mid_rst_req_ready", 32'(req_ready_w[0]), 0);
    check_eq("mid_rst_grant",     32'(grant_w[0]),     0);
    check_eq("mid_rst_busy",      32'(busy_w[0]),      0);
    check_eq("mid_rst_pending",   32'(exp_q.size()),   0);
    push_src(0, 8'hD0);
    push_src(0, 8'hFF);
    push_exp(1'b0, 8'hE0, 4'b0001);
    push_exp(1'b0, 8'hD0, 4'b0001);
    push_exp(1'b0, 8'hFF, 4'b0001);
    push_exp(1'b0, 8'hE2, 4'b0100);
    push_exp(1'b0, 8'hB1, 4'b0100);
    push_exp(1'b0, 8'hFF, 4'b0100);
    @(negedge Clk);
    reset = 1'b0;
    wait_idle(600);

    // Headerless instance, source 3 alone.
    sel = 1'b1;
    do_reset();
    base0 = ready_cnt[1][3];
    push_exp(1'b1, 8'h10, 4'b1000);
    push_exp(1'b1, 8'hFF, 4'b1000);
    push_src(3, 8'h10);
    push_src(3, 8'hFF);
    wait_idle(300);
    check_eq("t5_ready_src3", 32'(ready_cnt[1][3] - base0), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : p_timeout
    #500000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
